// File: rtl/alu_pipe_if.sv
// alu_pipe handshake bundle: operand side and result side.
// Flag signals exist only when ALU_FLAGS_EN is defined.
interface alu_pipe_if #(
  parameter int W = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2:0]     s;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] y;
`ifdef ALU_FLAGS_EN
  logic           zf;
  logic           cf;

  modport master (
    output in_valid, a, b, s, out_ready,
    input  in_ready, out_valid, y, zf, cf
  );

  modport slave (
    input  in_valid, a, b, s, out_ready,
    output in_ready, out_valid, y, zf, cf
  );
`else
  modport master (
    output in_valid, a, b, s, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, s, out_ready,
    output in_ready, out_valid, y
  );
`endif
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU with shift-add multiplier, result held until taken.
// Optional zero/carry flags: define ALU_FLAGS_EN.
module alu_pipe #(
  parameter  int W  = 4,
  localparam int CW = $clog2(W + 1)
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [2:0] OP_MUL  = 3'b010;

  logic [1:0]     state_q, state_d;
  logic [2*W-1:0] y_q, y_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [2*W-1:0] a_ext, b_ext;
  logic [2*W-1:0] sum, dif;
  logic [2*W-1:0] alu_y;
  logic [2*W-1:0] acc_nx;

`ifdef ALU_FLAGS_EN
  logic zf_q, zf_d;
  logic cf_q, cf_d;
  logic alu_c;
`endif

  assign a_ext = {{W{1'b0}}, bus.a};
  assign b_ext = {{W{1'b0}}, bus.b};
  assign sum   = a_ext + b_ext;
  assign dif   = a_ext - b_ext;

  // single-cycle result for the op on the bus
  always_comb begin
    alu_y = '0;
    unique case (bus.s)
      3'b000: alu_y = sum;
      3'b001: alu_y = dif;
      3'b010: alu_y = '0;
      3'b011: alu_y = a_ext & b_ext;
      3'b100: alu_y = a_ext | b_ext;
      3'b101: alu_y = a_ext ^ b_ext;
      3'b110: alu_y = {{W{1'b0}}, ~bus.a};
      3'b111: alu_y = {{(2*W-1){1'b0}},
                       (bus.a > bus.b)};
    endcase
  end

`ifdef ALU_FLAGS_EN
  // carry for add, borrow for sub, else 0
  always_comb begin
    alu_c = 1'b0;
    unique case (bus.s)
      3'b000:  alu_c = sum[W];
      3'b001:  alu_c = (bus.a < bus.b);
      default: alu_c = 1'b0;
    endcase
  end
`endif

  // one shift-add step of the multiplier
  assign acc_nx = acc_q +
                  (mplier_q[0] ? mcand_q : '0);

  // FSM and datapath next state
  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`ifdef ALU_FLAGS_EN
    zf_d     = zf_q;
    cf_d     = cf_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (bus.s == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = a_ext;
            mplier_d = bus.b;
            cnt_d    = '0;
            state_d  = ST_MUL;
          end else begin
            y_d     = alu_y;
`ifdef ALU_FLAGS_EN
            zf_d    = (alu_y == '0);
            cf_d    = alu_c;
`endif
            state_d = ST_HOLD;
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          y_d     = acc_nx;
`ifdef ALU_FLAGS_EN
          zf_d    = (acc_nx == '0);
          cf_d    = 1'b0;
`endif
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state registers, async reset aborts any op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      y_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`ifdef ALU_FLAGS_EN
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`ifdef ALU_FLAGS_EN
      zf_q     <= zf_d;
      cf_q     <= cf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.y         = y_q;
`ifdef ALU_FLAGS_EN
  assign bus.zf        = zf_q;
  assign bus.cf        = cf_q;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at W=4 and W=8.
// Flag checks are active when ALU_FLAGS_EN is defined.
module tb_alu_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_pipe_if #(.W(4)) b4 ();
  alu_pipe_if #(.W(8)) b8 ();

  alu_pipe #(.W(4)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (b4.slave)
  );

  alu_pipe #(.W(8)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  int vecs = 0;
  int errs = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic run4(input string tag,
                      input logic [3:0] a,
                      input logic [3:0] b,
                      input logic [2:0] s,
                      input logic [7:0] ey,
                      input int lat,
                      input logic ezf,
                      input logic ecf);
    int n;
    @(negedge clk);
    b4.a = a; b4.b = b; b4.s = s;
    b4.in_valid = 1'b1;
    check({tag, "_rdy"}, 32'(b4.in_ready), 1);
    @(negedge clk);
    b4.in_valid = 1'b0;
    b4.a = ~a; b4.b = ~b; b4.s = ~s;
    if (lat > 1)
      check({tag, "_busy"}, 32'(b4.in_ready), 0);
    n = 1;
    while (!b4.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_y"}, 32'(b4.y), 32'(ey));
`ifdef ALU_FLAGS_EN
    check({tag, "_zf"}, 32'(b4.zf), 32'(ezf));
    check({tag, "_cf"}, 32'(b4.cf), 32'(ecf));
`else
    if (ezf === 1'bx || ecf === 1'bx)
      $display("note: %s flag x", tag);
`endif
    b4.out_ready = 1'b1;
    @(negedge clk);
    b4.out_ready = 1'b0;
    check({tag, "_done"}, 32'(b4.out_valid), 0);
  endtask

  task automatic run8(input string tag,
                      input logic [7:0] a,
                      input logic [7:0] b,
                      input logic [2:0] s,
                      input logic [15:0] ey,
                      input int lat,
                      input logic ecf);
    int n;
    @(negedge clk);
    b8.a = a; b8.b = b; b8.s = s;
    b8.in_valid = 1'b1;
    @(negedge clk);
    b8.in_valid = 1'b0;
    b8.a = '0; b8.b = '0;
    n = 1;
    while (!b8.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_y"}, 32'(b8.y), 32'(ey));
`ifdef ALU_FLAGS_EN
    check({tag, "_cf"}, 32'(b8.cf), 32'(ecf));
`else
    if (ecf === 1'bx)
      $display("note: %s flag x", tag);
`endif
    b8.out_ready = 1'b1;
    @(negedge clk);
    b8.out_ready = 1'b0;
    check({tag, "_done"}, 32'(b8.out_valid), 0);
  endtask

  initial begin
    logic seen;
    logic stable;
    rst = 1'b0;
    b4.in_valid = 1'b0; b4.out_ready = 1'b0;
    b4.a = '0; b4.b = '0; b4.s = '0;
    b8.in_valid = 1'b0; b8.out_ready = 1'b0;
    b8.a = '0; b8.b = '0; b8.s = '0;

    #3 rst = 1'b1;
    #1;
    check("rst_y", 32'(b4.y), 0);
    check("rst_ov", 32'(b4.out_valid), 0);
    check("rst_ir", 32'(b4.in_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    run4("add", 4'b1001, 4'b0011, 3'b000,
         8'h0C, 1, 1'b0, 1'b0);
    run4("sub", 4'b1001, 4'b1011, 3'b001,
         8'hFE, 1, 1'b0, 1'b1);
    run4("mul97", 4'b1001, 4'b0111, 3'b010,
         8'h3F, 5, 1'b0, 1'b0);
    run4("mulff", 4'b1111, 4'b1111, 3'b010,
         8'hE1, 5, 1'b0, 1'b0);
    run4("mul0", 4'b0000, 4'b1011, 3'b010,
         8'h00, 5, 1'b1, 1'b0);
    run4("and", 4'b1101, 4'b1011, 3'b011,
         8'h09, 1, 1'b0, 1'b0);
    run4("or", 4'b1011, 4'b0111, 3'b100,
         8'h0F, 1, 1'b0, 1'b0);
    run4("xor", 4'b1010, 4'b1011, 3'b101,
         8'h01, 1, 1'b0, 1'b0);
    run4("not", 4'b1110, 4'b0000, 3'b110,
         8'h01, 1, 1'b0, 1'b0);
    run4("gt0", 4'b0101, 4'b1011, 3'b111,
         8'h00, 1, 1'b1, 1'b0);
    run4("gt1", 4'b1011, 4'b0101, 3'b111,
         8'h01, 1, 1'b0, 1'b0);

    // reset two cycles into a multiply
    @(negedge clk);
    b4.a = 4'b1001; b4.b = 4'b0111;
    b4.s = 3'b010; b4.in_valid = 1'b1;
    @(negedge clk);
    b4.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_y", 32'(b4.y), 0);
    check("abort_ov", 32'(b4.out_valid), 0);
    check("abort_ir", 32'(b4.in_ready), 1);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen |= b4.out_valid;
    end
    check("abort_nopulse", 32'(seen), 0);

    // backpressure in HOLD
    @(negedge clk);
    b4.a = 4'b1001; b4.b = 4'b0011;
    b4.s = 3'b000; b4.in_valid = 1'b1;
    @(negedge clk);
    b4.in_valid = 1'b0;
    check("bp_ov", 32'(b4.out_valid), 1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b4.in_valid = ~b4.in_valid;
      b4.a = 4'($urandom);
      b4.b = 4'($urandom);
      b4.s = 3'($urandom);
      @(negedge clk);
      if (b4.y !== 8'h0C || b4.in_ready !== 1'b0
          || b4.out_valid !== 1'b1)
        stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 1);
    b4.in_valid = 1'b0;
    b4.out_ready = 1'b1;
    @(negedge clk);
    b4.out_ready = 1'b0;
    check("bp_idle_ov", 32'(b4.out_valid), 0);
    check("bp_idle_ir", 32'(b4.in_ready), 1);
    check("bp_keep_y", 32'(b4.y), 32'h0C);

    run8("w8mul", 8'hFF, 8'hFF, 3'b010,
         16'hFE01, 9, 1'b0);
    run8("w8add", 8'hFF, 8'hFF, 3'b000,
         16'h01FE, 1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
